// File: rtl/rv32im_decode_stage_if.sv
// Bundle between IF/ID, the decode stage and EX: instruction handshake in, control word out.
interface rv32im_decode_stage_if;
    logic        instr_valid;
    logic [31:0] instruction;
    logic        busywait;
    logic        flush;
    logic        stall;
    logic        ctrl_valid;
    logic [4:0]  aluop;
    logic [2:0]  immsel;
    logic        alusrc_a;
    logic        alusrc_b;
    logic        memread;
    logic        memwrite;
    logic [2:0]  memsize;
    logic        regwrite;
    logic [1:0]  wbsel;
    logic        branch;
    logic [2:0]  brfunc;
    logic        jump;
    logic        jalr;
    logic        illegal;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    modport master (
        output instr_valid, instruction, busywait, flush,
        input  stall, ctrl_valid, aluop, immsel, alusrc_a, alusrc_b, memread, memwrite,
               memsize, regwrite, wbsel, branch, brfunc, jump, jalr, illegal, rd, rs1, rs2
    );

    modport slave (
        input  instr_valid, instruction, busywait, flush,
        output stall, ctrl_valid, aluop, immsel, alusrc_a, alusrc_b, memread, memwrite,
               memsize, regwrite, wbsel, branch, brfunc, jump, jalr, illegal, rd, rs1, rs2
    );
endinterface

// File: rtl/rv32im_decode_stage.sv
// RV32IM decode stage: registered control word, illegal-instruction flag, and stall
// generation for outstanding memory accesses and multi-cycle MUL/DIV ops.
module rv32im_decode_stage #(
    parameter bit          M_EXT       = 1'b1,
    parameter int unsigned MUL_LATENCY = 1,
    parameter int unsigned DIV_LATENCY = 32,
    parameter int unsigned CNT_W       = 6
) (
    input logic                  clk,
    input logic                  reset,
    rv32im_decode_stage_if.slave bus
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    localparam logic [4:0] AluAdd   = 5'd0;
    localparam logic [4:0] AluSub   = 5'd1;
    localparam logic [4:0] AluSll   = 5'd2;
    localparam logic [4:0] AluSlt   = 5'd3;
    localparam logic [4:0] AluSltu  = 5'd4;
    localparam logic [4:0] AluXor   = 5'd5;
    localparam logic [4:0] AluSrl   = 5'd6;
    localparam logic [4:0] AluSra   = 5'd7;
    localparam logic [4:0] AluOr    = 5'd8;
    localparam logic [4:0] AluAnd   = 5'd9;
    localparam logic [4:0] AluPassB = 5'd10;
    localparam logic [4:0] AluMul   = 5'd11;
    localparam logic [4:0] AluMulhu = 5'd14;
    localparam logic [4:0] AluDiv   = 5'd15;
    localparam logic [4:0] AluRemu  = 5'd18;

    localparam logic [2:0] ImmI = 3'd1;
    localparam logic [2:0] ImmS = 3'd2;
    localparam logic [2:0] ImmB = 3'd3;
    localparam logic [2:0] ImmU = 3'd4;
    localparam logic [2:0] ImmJ = 3'd5;

    localparam logic [6:0] F7Zero = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;
    localparam logic [6:0] F7Mext = 7'b0000001;

    typedef struct packed {
        logic       valid;
        logic [4:0] aluop;
        logic [2:0] immsel;
        logic       alusrc_a;
        logic       alusrc_b;
        logic       memread;
        logic       memwrite;
        logic [2:0] memsize;
        logic       regwrite;
        logic [1:0] wbsel;
        logic       branch;
        logic [2:0] brfunc;
        logic       jump;
        logic       jalr;
        logic       illegal;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctrl_t;

    typedef enum logic [1:0] {StRun, StMemWait, StMdWait} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl_q, ctrl_d;
    ctrl_t            raw, dec;
    logic             dec_ok;
    logic             stall, flush_eff, accept;
    logic             is_mem, is_mul, is_div;

    logic [6:0] opcode, f7;
    logic [2:0] f3;

    assign opcode = bus.instruction[6:0];
    assign f3     = bus.instruction[14:12];
    assign f7     = bus.instruction[31:25];

    always_comb begin
        raw          = '0;
        dec_ok       = 1'b1;
        raw.valid    = 1'b1;
        raw.rd       = bus.instruction[11:7];
        raw.rs1      = bus.instruction[19:15];
        raw.rs2      = bus.instruction[24:20];
        case (opcode)
            OpLui: begin
                raw.aluop    = AluPassB;
                raw.immsel   = ImmU;
                raw.alusrc_b = 1'b1;
                raw.regwrite = 1'b1;
            end
            OpAuipc: begin
                raw.aluop    = AluAdd;
                raw.immsel   = ImmU;
                raw.alusrc_a = 1'b1;
                raw.alusrc_b = 1'b1;
                raw.regwrite = 1'b1;
            end
            OpJal: begin
                raw.jump     = 1'b1;
                raw.immsel   = ImmJ;
                raw.alusrc_a = 1'b1;
                raw.alusrc_b = 1'b1;
                raw.wbsel    = 2'd2;
                raw.regwrite = 1'b1;
            end
            OpJalr: begin
                dec_ok       = (f3 == 3'b000);
                raw.jalr     = 1'b1;
                raw.immsel   = ImmI;
                raw.alusrc_b = 1'b1;
                raw.wbsel    = 2'd2;
                raw.regwrite = 1'b1;
            end
            OpBranch: begin
                dec_ok     = (f3 != 3'b010) && (f3 != 3'b011);
                raw.aluop  = AluSub;
                raw.immsel = ImmB;
                raw.branch = 1'b1;
                raw.brfunc = f3;
            end
            OpLoad: begin
                dec_ok       = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
                raw.immsel   = ImmI;
                raw.alusrc_b = 1'b1;
                raw.memread  = 1'b1;
                raw.memsize  = f3;
                raw.wbsel    = 2'd1;
                raw.regwrite = 1'b1;
            end
            OpStore: begin
                dec_ok       = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
                raw.immsel   = ImmS;
                raw.alusrc_b = 1'b1;
                raw.memwrite = 1'b1;
                raw.memsize  = f3;
            end
            OpImm: begin
                raw.immsel   = ImmI;
                raw.alusrc_b = 1'b1;
                raw.regwrite = 1'b1;
                case (f3)
                    3'b000: raw.aluop = AluAdd;
                    3'b001: begin
                        raw.aluop = AluSll;
                        dec_ok    = (f7 == F7Zero);
                    end
                    3'b010: raw.aluop = AluSlt;
                    3'b011: raw.aluop = AluSltu;
                    3'b100: raw.aluop = AluXor;
                    3'b101: begin
                        raw.aluop = (f7 == F7Alt) ? AluSra : AluSrl;
                        dec_ok    = (f7 == F7Zero) || (f7 == F7Alt);
                    end
                    3'b110: raw.aluop = AluOr;
                    default: raw.aluop = AluAnd;
                endcase
            end
            OpReg: begin
                raw.regwrite = 1'b1;
                if (f7 == F7Zero) begin
                    case (f3)
                        3'b000: raw.aluop = AluAdd;
                        3'b001: raw.aluop = AluSll;
                        3'b010: raw.aluop = AluSlt;
                        3'b011: raw.aluop = AluSltu;
                        3'b100: raw.aluop = AluXor;
                        3'b101: raw.aluop = AluSrl;
                        3'b110: raw.aluop = AluOr;
                        default: raw.aluop = AluAnd;
                    endcase
                end else if (f7 == F7Alt && f3 == 3'b000) begin
                    raw.aluop = AluSub;
                end else if (f7 == F7Alt && f3 == 3'b101) begin
                    raw.aluop = AluSra;
                end else if (f7 == F7Mext && M_EXT) begin
                    // MUL..REMU are contiguous codes ordered by func3.
                    raw.aluop = AluMul + {2'b00, f3};
                end else begin
                    dec_ok = 1'b0;
                end
            end
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        dec = raw;
        if (!dec_ok) begin
            dec         = '0;
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
            dec.rd      = raw.rd;
            dec.rs1     = raw.rs1;
            dec.rs2     = raw.rs2;
        end else if (raw.rd == 5'd0) begin
            dec.regwrite = 1'b0;
        end
    end

    assign is_mem = dec.memread | dec.memwrite;
    assign is_mul = (dec.aluop >= AluMul) && (dec.aluop <= AluMulhu);
    assign is_div = (dec.aluop >= AluDiv) && (dec.aluop <= AluRemu);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        stall     = 1'b0;
        unique case (state_q)
            StMemWait: stall = bus.busywait;
            StMdWait:  stall = (cnt_q != '0);
            default:   stall = 1'b0;
        endcase
        // An issued memory op cannot be cancelled until the memory releases it.
        flush_eff = bus.flush && !(state_q == StMemWait && bus.busywait);
        accept    = bus.instr_valid && !stall && !bus.flush;

        if (flush_eff) begin
            state_d = StRun;
            cnt_d   = '0;
            ctrl_d  = '0;
        end else if (accept) begin
            ctrl_d  = dec;
            state_d = StRun;
            cnt_d   = '0;
            if (is_mem) begin
                state_d = StMemWait;
            end else if (is_mul && MUL_LATENCY > 1) begin
                state_d = StMdWait;
                cnt_d   = CNT_W'(MUL_LATENCY - 1);
            end else if (is_div && DIV_LATENCY > 1) begin
                state_d = StMdWait;
                cnt_d   = CNT_W'(DIV_LATENCY - 1);
            end
        end else if (stall) begin
            if (state_q == StMdWait) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else begin
            state_d = StRun;
            cnt_d   = '0;
            ctrl_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StRun;
            cnt_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.stall      = stall;
    assign bus.ctrl_valid = ctrl_q.valid;
    assign bus.aluop      = ctrl_q.aluop;
    assign bus.immsel     = ctrl_q.immsel;
    assign bus.alusrc_a   = ctrl_q.alusrc_a;
    assign bus.alusrc_b   = ctrl_q.alusrc_b;
    assign bus.memread    = ctrl_q.memread;
    assign bus.memwrite   = ctrl_q.memwrite;
    assign bus.memsize    = ctrl_q.memsize;
    assign bus.regwrite   = ctrl_q.regwrite;
    assign bus.wbsel      = ctrl_q.wbsel;
    assign bus.branch     = ctrl_q.branch;
    assign bus.brfunc     = ctrl_q.brfunc;
    assign bus.jump       = ctrl_q.jump;
    assign bus.jalr       = ctrl_q.jalr;
    assign bus.illegal    = ctrl_q.illegal;
    assign bus.rd         = ctrl_q.rd;
    assign bus.rs1        = ctrl_q.rs1;
    assign bus.rs2        = ctrl_q.rs2;

endmodule

// File: tb/tb_rv32im_decode_stage.sv
// Directed bench for rv32im_decode_stage: one DUT with M enabled and DIV_LATENCY=4,
// one with M disabled.
module tb_rv32im_decode_stage;

    localparam logic [31:0] InsAdd   = 32'h002081B3;
    localparam logic [31:0] InsAddX0 = 32'h00208033;
    localparam logic [31:0] InsLw    = 32'h0040A183;
    localparam logic [31:0] InsSw    = 32'h0020A023;
    localparam logic [31:0] InsDiv   = 32'h0220C1B3;
    localparam logic [31:0] InsMul   = 32'h022081B3;
    localparam logic [31:0] InsLui   = 32'h123450B7;
    localparam logic [31:0] InsBne   = 32'h00209463;
    localparam logic [31:0] InsJal   = 32'h008000EF;
    localparam logic [31:0] InsBadSl = 32'h40109093;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    rv32im_decode_stage_if bus_a ();
    rv32im_decode_stage_if bus_b ();

    rv32im_decode_stage #(
        .M_EXT       (1'b1),
        .MUL_LATENCY (1),
        .DIV_LATENCY (4),
        .CNT_W       (6)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    rv32im_decode_stage #(
        .M_EXT       (1'b0),
        .MUL_LATENCY (1),
        .DIV_LATENCY (4),
        .CNT_W       (6)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus_a.instr_valid = 1'b1;
        bus_a.instruction = InsAdd;
        bus_a.busywait    = 1'b0;
        bus_a.flush       = 1'b0;
        bus_b.instr_valid = 1'b0;
        bus_b.instruction = 32'h0;
        bus_b.busywait    = 1'b0;
        bus_b.flush       = 1'b0;

        // Reset held two edges with a valid ADD presented
        tick();
        tick();
        check("rst_valid", {31'd0, bus_a.ctrl_valid}, 32'd0);
        check("rst_regwrite", {31'd0, bus_a.regwrite}, 32'd0);
        check("rst_rd", {27'd0, bus_a.rd}, 32'd0);
        check("rst_aluop", {27'd0, bus_a.aluop}, 32'd0);
        check("rst_stall", {31'd0, bus_a.stall}, 32'd0);
        reset = 1'b1;

        // ADD x3,x1,x2
        tick();
        check("add_valid", {31'd0, bus_a.ctrl_valid}, 32'd1);
        check("add_aluop", {27'd0, bus_a.aluop}, 32'd0);
        check("add_regwrite", {31'd0, bus_a.regwrite}, 32'd1);
        check("add_rd", {27'd0, bus_a.rd}, 32'd3);
        check("add_rs1", {27'd0, bus_a.rs1}, 32'd1);
        check("add_rs2", {27'd0, bus_a.rs2}, 32'd2);
        check("add_srcb", {31'd0, bus_a.alusrc_b}, 32'd0);
        check("add_illegal", {31'd0, bus_a.illegal}, 32'd0);

        // LW x3,4(x1) with memory busy for three cycles
        bus_a.instruction = InsLw;
        bus_a.busywait    = 1'b1;
        tick();
        bus_a.instruction = InsAdd;
        #1;
        check("lw_memread", {31'd0, bus_a.memread}, 32'd1);
        check("lw_memsize", {29'd0, bus_a.memsize}, 32'd2);
        check("lw_wbsel", {30'd0, bus_a.wbsel}, 32'd1);
        check("lw_immsel", {29'd0, bus_a.immsel}, 32'd1);
        check("lw_stall1", {31'd0, bus_a.stall}, 32'd1);
        tick();
        check("lw_hold", {31'd0, bus_a.memread}, 32'd1);
        check("lw_stall2", {31'd0, bus_a.stall}, 32'd1);
        tick();
        check("lw_stall3", {31'd0, bus_a.stall}, 32'd1);
        bus_a.busywait = 1'b0;
        #1;
        check("lw_release", {31'd0, bus_a.stall}, 32'd0);
        tick();
        check("lw_next_memread", {31'd0, bus_a.memread}, 32'd0);
        check("lw_next_aluop", {27'd0, bus_a.aluop}, 32'd0);
        check("lw_next_regwrite", {31'd0, bus_a.regwrite}, 32'd1);
        bus_a.busywait = 1'b1;
        #1;
        check("run_ignores_busy", {31'd0, bus_a.stall}, 32'd0);
        bus_a.busywait = 1'b0;

        // DIV x3,x1,x2: word held four cycles, stall for three
        bus_a.instruction = InsDiv;
        tick();
        bus_a.instruction = InsAdd;
        check("div_aluop_c1", {27'd0, bus_a.aluop}, 32'd15);
        check("div_stall_c1", {31'd0, bus_a.stall}, 32'd1);
        tick();
        check("div_aluop_c2", {27'd0, bus_a.aluop}, 32'd15);
        check("div_stall_c2", {31'd0, bus_a.stall}, 32'd1);
        tick();
        check("div_aluop_c3", {27'd0, bus_a.aluop}, 32'd15);
        check("div_stall_c3", {31'd0, bus_a.stall}, 32'd1);
        tick();
        check("div_aluop_c4", {27'd0, bus_a.aluop}, 32'd15);
        check("div_stall_c4", {31'd0, bus_a.stall}, 32'd0);
        tick();
        check("div_next_aluop", {27'd0, bus_a.aluop}, 32'd0);
        check("div_next_valid", {31'd0, bus_a.ctrl_valid}, 32'd1);

        // FLUSH during cycle 2 of a DIV hold
        bus_a.instruction = InsDiv;
        tick();
        bus_a.instruction = InsAdd;
        tick();
        bus_a.flush = 1'b1;
        tick();
        bus_a.flush = 1'b0;
        check("flush_valid", {31'd0, bus_a.ctrl_valid}, 32'd0);
        check("flush_regwrite", {31'd0, bus_a.regwrite}, 32'd0);
        check("flush_aluop", {27'd0, bus_a.aluop}, 32'd0);
        check("flush_stall", {31'd0, bus_a.stall}, 32'd0);
        tick();
        check("after_flush_valid", {31'd0, bus_a.ctrl_valid}, 32'd1);
        check("after_flush_regwrite", {31'd0, bus_a.regwrite}, 32'd1);

        // Assorted opcodes
        bus_a.instruction = InsMul;
        tick();
        check("mul_aluop", {27'd0, bus_a.aluop}, 32'd11);
        check("mul_stall", {31'd0, bus_a.stall}, 32'd0);
        bus_a.instruction = InsLui;
        tick();
        check("lui_aluop", {27'd0, bus_a.aluop}, 32'd10);
        check("lui_immsel", {29'd0, bus_a.immsel}, 32'd4);
        check("lui_srcb", {31'd0, bus_a.alusrc_b}, 32'd1);
        bus_a.instruction = InsBne;
        tick();
        check("bne_branch", {31'd0, bus_a.branch}, 32'd1);
        check("bne_brfunc", {29'd0, bus_a.brfunc}, 32'd1);
        check("bne_aluop", {27'd0, bus_a.aluop}, 32'd1);
        check("bne_regwrite", {31'd0, bus_a.regwrite}, 32'd0);
        bus_a.instruction = InsJal;
        tick();
        check("jal_jump", {31'd0, bus_a.jump}, 32'd1);
        check("jal_wbsel", {30'd0, bus_a.wbsel}, 32'd2);
        check("jal_immsel", {29'd0, bus_a.immsel}, 32'd5);
        bus_a.instruction = InsSw;
        tick();
        check("sw_memwrite", {31'd0, bus_a.memwrite}, 32'd1);
        check("sw_regwrite", {31'd0, bus_a.regwrite}, 32'd0);
        check("sw_immsel", {29'd0, bus_a.immsel}, 32'd2);
        check("sw_stall", {31'd0, bus_a.stall}, 32'd0);
        bus_a.instruction = InsBadSl;
        tick();
        check("badsl_illegal", {31'd0, bus_a.illegal}, 32'd1);
        check("badsl_valid", {31'd0, bus_a.ctrl_valid}, 32'd1);
        check("badsl_regwrite", {31'd0, bus_a.regwrite}, 32'd0);
        bus_a.instr_valid = 1'b0;
        tick();
        check("idle_valid", {31'd0, bus_a.ctrl_valid}, 32'd0);
        check("idle_illegal", {31'd0, bus_a.illegal}, 32'd0);

        // M extension disabled
        bus_b.instr_valid = 1'b1;
        bus_b.instruction = InsMul;
        tick();
        check("nom_valid", {31'd0, bus_b.ctrl_valid}, 32'd1);
        check("nom_illegal", {31'd0, bus_b.illegal}, 32'd1);
        check("nom_regwrite", {31'd0, bus_b.regwrite}, 32'd0);
        check("nom_stall", {31'd0, bus_b.stall}, 32'd0);
        bus_b.instruction = InsAddX0;
        tick();
        check("x0_valid", {31'd0, bus_b.ctrl_valid}, 32'd1);
        check("x0_regwrite", {31'd0, bus_b.regwrite}, 32'd0);
        check("x0_illegal", {31'd0, bus_b.illegal}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
